valid_proxy: RTL

VALID_PROXY -- requirements
Module: valid_proxy

---
 rtl/valid_proxy.sv | 116 +++++++++++
 1 files changed

// File: rtl/valid_proxy.sv
// Forward-registered valid/ready pipeline of STAGES (1..4) stages with bubble collapse.
// Also provides occupancy, a wrapping transfer counter and a saturating stall counter.
module valid_proxy #(
  parameter int DATA_W = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] up_data,
  input  logic              up_valid,
  output logic              up_ready,
  output logic [DATA_W-1:0] down_data,
  output logic              down_valid,
  input  logic              down_ready,
  output logic [2:0]        occupancy,
  output logic [15:0]       xfer_cnt,
  output logic [15:0]       stall_cnt
);

  logic [STAGES-1:0] r_v;
  logic [DATA_W-1:0] r_d [STAGES];
  logic [15:0]       r_xfer;
  logic [15:0]       r_stall;

  logic [STAGES-1:0] w_rdy;
  logic [STAGES-1:0] w_mask;
  logic [STAGES-1:0] w_in_v;
  logic [DATA_W-1:0] w_in_d [STAGES];
  logic              w_xfer;
  logic              w_stall;

  function automatic logic [2:0] f_popcount(input logic [STAGES-1:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int k = 0; k < STAGES; k++) begin
      c = c + {2'b00, v[k]};
    end
    return c;
  endfunction

  // Stage k is ready unless it and every stage downstream of it is full while
  // downstream stalls; this is the r[k] = ~v[k] | r[k+1] chain unrolled.
  always_comb begin
    w_mask = '0;
    w_rdy  = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_mask   = {STAGES{1'b1}} << k;
      w_rdy[k] = down_ready | ~(&(r_v | ~w_mask));
    end
  end

  // Input of each stage: upstream port for stage 0, previous stage otherwise.
  always_comb begin
    w_in_v    = '0;
    w_in_v[0] = up_valid;
    w_in_d[0] = up_data;
    for (int k = 1; k < STAGES; k++) begin
      w_in_v[k] = r_v[k-1];
      w_in_d[k] = r_d[k-1];
    end
  end

  // Pipeline stage registers; data only loads when the incoming valid is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_d[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_v[k] <= w_in_v[k];
          if (w_in_v[k]) begin
            r_d[k] <= w_in_d[k];
          end else begin
            r_d[k] <= r_d[k];
          end
        end else begin
          r_v[k] <= r_v[k];
          r_d[k] <= r_d[k];
        end
      end
    end
  end

  assign w_xfer  = r_v[STAGES-1] & down_ready;
  assign w_stall = r_v[STAGES-1] & ~down_ready;

  // Handshake counter wraps; stall counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer  <= 16'd0;
      r_stall <= 16'd0;
    end else begin
      if (w_xfer) begin
        r_xfer <= r_xfer + 16'd1;
      end else begin
        r_xfer <= r_xfer;
      end
      if (w_stall && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end else begin
        r_stall <= r_stall;
      end
    end
  end

  assign up_ready   = w_rdy[0];
  assign down_valid = r_v[STAGES-1];
  assign down_data  = r_d[STAGES-1];
  assign occupancy  = f_popcount(r_v);
  assign xfer_cnt   = r_xfer;
  assign stall_cnt  = r_stall;

endmodule
